// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - register file write-port arbiter between WB and a buffered MD result
module rf_writeback_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        rf_write_en,
    output logic [31:0] md_pending
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_reg_q, buf_reg_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        out_en_q, out_en_d;
    logic [4:0]  out_reg_q, out_reg_d;
    logic [31:0] out_data_q, out_data_d;
    logic        src_md_q, src_md_d;

    logic        grant_md;
    logic        grant_wb;
    logic [31:0] pending;

    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_reg_d    = buf_reg_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = starve_cnt_q;
        out_en_d     = 1'b0;
        out_reg_d    = out_reg_q;
        out_data_d   = out_data_q;
        src_md_d     = src_md_q;

        grant_md = buf_valid_q && ((starve_cnt_q == STARVE_LIM) || !wb_valid);
        grant_wb = wb_valid && !grant_md;
        md_ready = !rst && !buf_valid_q;
        wb_stall = !rst && wb_valid && grant_md;

        if (grant_md) begin
            out_en_d    = (buf_reg_q != 5'd0);
            out_reg_d   = buf_reg_q;
            out_data_d  = buf_data_q;
            src_md_d    = 1'b1;
            buf_valid_d = 1'b0;
        end else if (grant_wb) begin
            out_en_d   = (wb_reg != 5'd0);
            out_reg_d  = wb_reg;
            out_data_d = wb_data;
            src_md_d   = 1'b0;
            if (buf_valid_q && (starve_cnt_q != STARVE_LIM)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end

        // Results for r0 are swallowed here so they never occupy the buffer.
        if (md_valid && !buf_valid_q && (md_reg != 5'd0)) begin
            buf_valid_d = 1'b1;
            buf_reg_d   = md_reg;
            buf_data_d  = md_data;
        end

        if (!buf_valid_d) begin
            starve_cnt_d = 4'd0;
        end

        pending = 32'd0;
        if (buf_valid_q) begin
            pending[buf_reg_q] = 1'b1;
        end
        if (out_en_q && src_md_q) begin
            pending[out_reg_q] = 1'b1;
        end
        md_pending = rst ? 32'd0 : pending;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q  <= 1'b0;
            buf_reg_q    <= 5'd0;
            buf_data_q   <= 32'd0;
            starve_cnt_q <= 4'd0;
            out_en_q     <= 1'b0;
            out_reg_q    <= 5'd0;
            out_data_q   <= 32'd0;
            src_md_q     <= 1'b0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_reg_q    <= buf_reg_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            out_en_q     <= out_en_d;
            out_reg_q    <= out_reg_d;
            out_data_q   <= out_data_d;
            src_md_q     <= src_md_d;
        end
    end

    assign rf_write_en   = out_en_q && !rst;
    assign rf_write_reg  = out_reg_q;
    assign rf_write_data = out_data_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - directed and randomized checks of rf_writeback_arbiter against a reference model
module tb_rf_writeback_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rf_write_en;
    logic [31:0] md_pending;

    int vectors = 0;
    int miscompares = 0;

    rf_writeback_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_write_en(rf_write_en), .md_pending(md_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one-entry buffer, loss counter, and the write scheduled for the next cycle.
    logic        model_ok = 1'b0;
    logic        mb_v = 1'b0;
    logic [4:0]  mb_r = '0;
    logic [31:0] mb_d = '0;
    int          miss = 0;
    logic        mo_en = 1'b0;
    logic [4:0]  mo_r = '0;
    logic [31:0] mo_d = '0;
    logic        mo_md = 1'b0;
    logic        last_stall = 1'b0;
    logic        last_ready = 1'b0;

    always @(negedge clk) begin
        logic take_md, take_wb, acc;
        logic [31:0] pend;
        if (rst) begin
            if (model_ok) begin
                check("m_rst_en", {31'd0, rf_write_en}, 32'd0);
                check("m_rst_ready", {31'd0, md_ready}, 32'd0);
                check("m_rst_stall", {31'd0, wb_stall}, 32'd0);
                check("m_rst_pend", md_pending, 32'd0);
            end
            mb_v = 0; miss = 0; mo_en = 0; mo_r = 0; mo_d = 0; mo_md = 0;
            model_ok = 1;
        end else if (model_ok) begin
            take_md = mb_v && (miss == SM || !wb_valid);
            take_wb = wb_valid && !take_md;
            pend = 32'd0;
            if (mb_v) pend = pend | (32'd1 << mb_r);
            if (mo_en && mo_md) pend = pend | (32'd1 << mo_r);
            check("m_ready", {31'd0, md_ready}, {31'd0, !mb_v});
            check("m_stall", {31'd0, wb_stall}, {31'd0, wb_valid && take_md});
            check("m_pend", md_pending, pend);
            check("m_en", {31'd0, rf_write_en}, {31'd0, mo_en});
            check("m_reg", {27'd0, rf_write_reg}, {27'd0, mo_r});
            check("m_data", rf_write_data, mo_d);
            acc = md_valid && !mb_v;
            if (take_md) begin
                mo_en = (mb_r != 0); mo_r = mb_r; mo_d = mb_d; mo_md = 1;
                mb_v = 0;
            end else if (take_wb) begin
                mo_en = (wb_reg != 0); mo_r = wb_reg; mo_d = wb_data; mo_md = 0;
                if (mb_v && miss < SM) miss = miss + 1;
            end else begin
                mo_en = 0;
            end
            if (acc && md_reg != 0) begin
                mb_v = 1; mb_r = md_reg; mb_d = md_data;
            end
            if (!mb_v) miss = 0;
        end
        last_stall = wb_stall;
        last_ready = md_ready;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; wb_valid = 0; wb_reg = 0; wb_data = 0; md_valid = 0; md_reg = 0; md_data = 0;
        sample();
        check("rst_ready", {31'd0, md_ready}, 32'd0);
        check("rst_pend", md_pending, 32'd0);
        check("rst_en", {31'd0, rf_write_en}, 32'd0);
        next_cycle(); rst = 0; sample();
        check("post_rst_ready", {31'd0, md_ready}, 32'd1);

        next_cycle(); wb_valid = 1; wb_reg = 5; wb_data = 32'h1234; sample();
        check("wb_stall0", {31'd0, wb_stall}, 32'd0);
        next_cycle(); wb_valid = 0; sample();
        check("wb_en", {31'd0, rf_write_en}, 32'd1);
        check("wb_reg", {27'd0, rf_write_reg}, 32'd5);
        check("wb_data", rf_write_data, 32'h1234);

        next_cycle(); md_valid = 1; md_reg = 9; md_data = 32'hDEADBEEF; sample();
        check("md_ready_c1", {31'd0, md_ready}, 32'd1);
        next_cycle(); md_valid = 0; sample();
        check("md_ready_c2", {31'd0, md_ready}, 32'd0);
        check("md_pend_c2", md_pending, 32'h200);
        next_cycle(); sample();
        check("md_en_c3", {31'd0, rf_write_en}, 32'd1);
        check("md_reg_c3", {27'd0, rf_write_reg}, 32'd9);
        check("md_data_c3", rf_write_data, 32'hDEADBEEF);
        check("md_pend_c3", md_pending, 32'h200);
        check("md_ready_c3", {31'd0, md_ready}, 32'd1);
        next_cycle(); sample();
        check("md_pend_c4", md_pending, 32'd0);

        next_cycle(); md_valid = 1; md_reg = 7; md_data = 32'h77; sample();
        next_cycle(); md_valid = 0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1; wb_reg = 5'(10 + i); wb_data = 32'(100 + i);
            sample();
            check("starve_nostall", {31'd0, wb_stall}, 32'd0);
            next_cycle();
        end
        wb_reg = 14; wb_data = 32'd114; sample();
        check("starve_stall", {31'd0, wb_stall}, 32'd1);
        next_cycle(); sample();
        check("starve_md_reg", {27'd0, rf_write_reg}, 32'd7);
        check("starve_md_en", {31'd0, rf_write_en}, 32'd1);
        check("starve_unstall", {31'd0, wb_stall}, 32'd0);
        next_cycle(); wb_valid = 0; sample();
        check("starve_wb_reg", {27'd0, rf_write_reg}, 32'd14);
        check("starve_wb_data", rf_write_data, 32'd114);

        next_cycle(); wb_valid = 1; wb_reg = 0; wb_data = 32'h5; sample();
        next_cycle(); wb_valid = 0; md_valid = 1; md_reg = 0; md_data = 32'h66; sample();
        check("r0_wb_en", {31'd0, rf_write_en}, 32'd0);
        next_cycle(); md_valid = 0; sample();
        check("r0_md_ready", {31'd0, md_ready}, 32'd1);
        check("r0_md_pend", md_pending, 32'd0);
        next_cycle(); sample();
        check("r0_md_en", {31'd0, rf_write_en}, 32'd0);

        next_cycle(); md_valid = 1; md_reg = 3; md_data = 32'h33; sample();
        next_cycle(); md_reg = 4; md_data = 32'h44; sample();
        check("b2b_ready_busy", {31'd0, md_ready}, 32'd0);
        next_cycle(); sample();
        check("b2b_en3", {31'd0, rf_write_en}, 32'd1);
        check("b2b_reg3", {27'd0, rf_write_reg}, 32'd3);
        check("b2b_ready_free", {31'd0, md_ready}, 32'd1);
        next_cycle(); md_valid = 0; sample();
        check("b2b_gap", {31'd0, rf_write_en}, 32'd0);
        next_cycle(); sample();
        check("b2b_en4", {31'd0, rf_write_en}, 32'd1);
        check("b2b_reg4", {27'd0, rf_write_reg}, 32'd4);

        next_cycle(); md_valid = 1; md_reg = 12; md_data = 32'hC; sample();
        next_cycle(); md_valid = 0; wb_valid = 1; wb_reg = 13; wb_data = 32'hD; sample();
        check("mid_wb_grant", {31'd0, wb_stall}, 32'd0);
        next_cycle(); wb_valid = 0; rst = 1; sample();
        check("mid_rst_en", {31'd0, rf_write_en}, 32'd0);
        check("mid_rst_ready", {31'd0, md_ready}, 32'd0);
        check("mid_rst_pend", md_pending, 32'd0);
        next_cycle(); rst = 0; sample();
        check("mid_after_en", {31'd0, rf_write_en}, 32'd0);
        check("mid_after_ready", {31'd0, md_ready}, 32'd1);
        check("mid_after_pend", md_pending, 32'd0);
        next_cycle(); sample();
        check("mid_never_written", {31'd0, rf_write_en}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 299) == 0);
            if (!(last_stall && wb_valid)) begin
                wb_valid = ($urandom_range(0, 99) < 60);
                wb_reg   = 5'($urandom_range(0, 31));
                wb_data  = $urandom;
            end
            if (!(md_valid && !last_ready)) begin
                md_valid = ($urandom_range(0, 99) < 40);
                md_reg   = 5'($urandom_range(0, 31));
                md_data  = $urandom;
            end
        end
        next_cycle(); rst = 0; wb_valid = 0; md_valid = 0;
        sample();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
